camera_pixel_capture: RTL and testbench
=======================================

Name: camera_pixel_capture

Overview:
- Front-end capture stage between the OV7670 parallel bus and the frame-buffer writer / image-processing logic.
- Runs on the camera pixel clock and samples CAMERA_DATA, HREF and VSYNC.
- Pairs bytes into RGB565 pixels, generates X/Y write addresses and a one-cycle write strobe.
- Reports frame and line boundaries and line-length errors, and clips everything outside the screen.

Parameters:
- SCREEN_WIDTH, 176, pixels per line written; later pixels are dropped.
- SCREEN_HEIGHT, 144, lines per frame written; later lines are dropped.
- ADDR_W, 8, width of X_ADDR and Y_ADDR.

Ports:
- CLK  input  1  camera pixel clock; all logic on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- CAMERA_DATA  input  8  camera byte bus.
- HREF  input  1  line-valid, high during active bytes.
- VSYNC  input  1  frame sync, high between frames.
- PIXEL_RGB565  output  16  assembled pixel.
- X_ADDR  output  ADDR_W  column of PIXEL_RGB565.
- Y_ADDR  output  ADDR_W  row of PIXEL_RGB565.
- W_EN  output  1  one-cycle write strobe, PIXEL_RGB565 and addresses valid.
- LINE_DONE  output  1  one-cycle pulse at end of each active line.
- FRAME_DONE  output  1  one-cycle pulse at end of each frame.
- LINE_COUNT  output  ADDR_W  lines in the last completed frame, saturating at 2^ADDR_W-1.
- LINE_ERR  output  1  sticky: odd byte count or line shorter than SCREEN_WIDTH seen in current frame.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in WAIT_VS, all counters 0.
- Input stage: CAMERA_DATA, HREF and VSYNC are registered once (d_q, href_q, vs_q); previous values are kept for edge detection. The FSM only uses registered values.
- States:
  - WAIT_VS: after reset, wait for vs_q falling edge, then go to WAIT_LINE with Y=0. Partial frames after reset are never captured.
  - WAIT_LINE: href_q=1 → capture d_q as low byte, go to BYTE_HI.
  - BYTE_HI: href_q=1 → PIXEL_RGB565={d_q, low byte}; if X<SCREEN_WIDTH and Y<SCREEN_HEIGHT, pulse W_EN with current X/Y; go to BYTE_LO.
  - BYTE_LO: href_q=1 → capture low byte, go to BYTE_HI.
  - Internal X increments after every assembled pixel, saturating at SCREEN_WIDTH.
- Line end: href_q falling edge in any of BYTE_LO/BYTE_HI:
  - pulse LINE_DONE; X←0; Y increments, saturating at 2^ADDR_W-1; go to WAIT_LINE.
  - If falling in BYTE_HI (odd byte count), discard the low byte and set LINE_ERR.
  - If pixels in the line < SCREEN_WIDTH, set LINE_ERR.
- Frame end: vs_q rising edge in any state except WAIT_VS:
  - pulse FRAME_DONE; LINE_COUNT←Y; go to WAIT_VS.
  - A line in progress is aborted with no LINE_DONE, and pending low bytes are discarded.
  - WAIT_VS then waits for the next falling edge, which clears LINE_ERR and Y.
- Latency: byte on pins at edge n is registered at n; W_EN/PIXEL_RGB565 are registered at n+1 (2-edge latency). X_ADDR/Y_ADDR are registered with the pixel and held until the next W_EN.
- Simultaneous href_q fall and vs_q rise: frame-end handling only (no LINE_DONE). LINE_COUNT counts completed lines only.
- HREF high while vs_q=1: ignored.
- Reset mid-line: outputs clear immediately; capture resumes only after a full VSYNC high→low.

Optional Feature:
- Macro: CAPTURE_TEST_PATTERN_EN.
- Defined: all timing, handshakes and addresses are unchanged, but PIXEL_RGB565 is replaced by eight vertical colour bars, each SCREEN_WIDTH/8 pixels wide (22 at default). Bar index = X/(SCREEN_WIDTH/8); colour = {5{idx[2]},6{idx[1]},5{idx[0]}}. Camera bytes are still consumed for pairing and error checks.
- Undefined: camera data passes through; no pattern logic is synthesised.

Test Plan:
- Reset, then VSYNC 1→0, then one HREF line of 352 bytes 0x00,0xF8 repeated → 176 W_EN pulses; PIXEL_RGB565=16'hF800, X_ADDR 0..175, Y_ADDR=0; one LINE_DONE; LINE_ERR=0.
- Full frame of 144 lines × 352 bytes, then VSYNC rises → 25344 W_EN pulses; FRAME_DONE once; LINE_COUNT=144; LINE_ERR=0.
- Line of 400 bytes → 176 W_EN pulses, nothing written for pixels 176..199; a 150-line frame writes Y 0..143 only and reports LINE_COUNT=150.
- Line of 351 bytes → 175 W_EN pulses; LINE_ERR=1 until the next VSYNC falling edge, then 0.
- Assert RESET_N=0 mid-line → all outputs 0 asynchronously. Release mid-frame → no W_EN until VSYNC high→low, then capture resumes at X=0, Y=0.
- With CAPTURE_TEST_PATTERN_EN defined, one full line → PIXEL_RGB565=16'h0000 at X=0..21, 16'h001F at X=22, 16'hFFFF at X=154..175.

Source files
------------

// File: rtl/camera_pixel_capture.sv
// OV7670 capture front end: pairs camera bytes into RGB565 pixels with X/Y addresses, clipping and line checks.
// Optional macro CAPTURE_TEST_PATTERN_EN replaces the pixel data with eight vertical colour bars.
module camera_pixel_capture #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [7:0]        CAMERA_DATA,
  input  logic              HREF,
  input  logic              VSYNC,
  output logic [15:0]       PIXEL_RGB565,
  output logic [ADDR_W-1:0] X_ADDR,
  output logic [ADDR_W-1:0] Y_ADDR,
  output logic              W_EN,
  output logic              LINE_DONE,
  output logic              FRAME_DONE,
  output logic [ADDR_W-1:0] LINE_COUNT,
  output logic              LINE_ERR
);
  localparam logic [ADDR_W:0]   SCR_W = (ADDR_W+1)'(SCREEN_WIDTH);
  localparam logic [ADDR_W:0]   SCR_H = (ADDR_W+1)'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] Y_MAX = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    WAIT_VS   = 2'd0,
    WAIT_LINE = 2'd1,
    BYTE_HI   = 2'd2,
    BYTE_LO   = 2'd3
  } state_t;

  state_t            state;
  logic [7:0]        d_q;
  logic              href_q;
  logic              vs_q;
  logic              href_prev;
  logic              vs_prev;
  logic [7:0]        lo_byte;
  logic [ADDR_W:0]   x_cnt;
  logic [ADDR_W-1:0] y_cnt;
  logic              vs_rise;
  logic              vs_fall;
  logic              href_fall;
  logic              in_screen;
  logic [ADDR_W:0]   x_next;
  logic [ADDR_W-1:0] y_next;
  logic [15:0]       pixel;

  assign vs_rise   = vs_q & ~vs_prev;
  assign vs_fall   = ~vs_q & vs_prev;
  assign href_fall = ~href_q & href_prev;
  assign in_screen = (x_cnt < SCR_W) && ({1'b0, y_cnt} < SCR_H);
  // X stops at the screen width so the short-line check still sees a full line after overruns.
  assign x_next    = (x_cnt == SCR_W) ? x_cnt : x_cnt + (ADDR_W+1)'(1);
  assign y_next    = (y_cnt == Y_MAX) ? y_cnt : y_cnt + ADDR_W'(1);

`ifdef CAPTURE_TEST_PATTERN_EN
  localparam logic [ADDR_W:0] BAR_W = (ADDR_W+1)'(SCREEN_WIDTH / 8);
  logic [ADDR_W:0] bar_idx;
  assign bar_idx = x_cnt / BAR_W;
  assign pixel   = {{5{bar_idx[2]}}, {6{bar_idx[1]}}, {5{bar_idx[0]}}};
`else
  assign pixel   = {d_q, lo_byte};
`endif

  // Input registers plus one-cycle history for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      d_q       <= 8'd0;
      href_q    <= 1'b0;
      vs_q      <= 1'b0;
      href_prev <= 1'b0;
      vs_prev   <= 1'b0;
    end else begin
      d_q       <= CAMERA_DATA;
      href_q    <= HREF;
      vs_q      <= VSYNC;
      href_prev <= href_q;
      vs_prev   <= vs_q;
    end
  end

  // Capture FSM with registered pixel, address, strobe and status outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= WAIT_VS;
      lo_byte      <= 8'd0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      PIXEL_RGB565 <= 16'd0;
      X_ADDR       <= '0;
      Y_ADDR       <= '0;
      W_EN         <= 1'b0;
      LINE_DONE    <= 1'b0;
      FRAME_DONE   <= 1'b0;
      LINE_COUNT   <= '0;
      LINE_ERR     <= 1'b0;
    end else begin
      W_EN       <= 1'b0;
      LINE_DONE  <= 1'b0;
      FRAME_DONE <= 1'b0;
      // Frame end wins over a coincident line end; the open line is abandoned uncounted.
      if (vs_rise && (state != WAIT_VS)) begin
        FRAME_DONE <= 1'b1;
        LINE_COUNT <= y_cnt;
        x_cnt      <= '0;
        state      <= WAIT_VS;
      end else begin
        case (state)
          WAIT_VS: begin
            if (vs_fall) begin
              x_cnt    <= '0;
              y_cnt    <= '0;
              LINE_ERR <= 1'b0;
              state    <= WAIT_LINE;
            end else begin
              state <= WAIT_VS;
            end
          end
          WAIT_LINE: begin
            if (href_q && !vs_q) begin
              lo_byte <= d_q;
              state   <= BYTE_HI;
            end else begin
              state <= WAIT_LINE;
            end
          end
          BYTE_HI: begin
            if (href_fall) begin
              LINE_DONE <= 1'b1;
              LINE_ERR  <= 1'b1;
              x_cnt     <= '0;
              y_cnt     <= y_next;
              state     <= WAIT_LINE;
            end else if (href_q) begin
              if (in_screen) begin
                W_EN         <= 1'b1;
                PIXEL_RGB565 <= pixel;
                X_ADDR       <= x_cnt[ADDR_W-1:0];
                Y_ADDR       <= y_cnt;
              end else begin
                W_EN <= 1'b0;
              end
              x_cnt <= x_next;
              state <= BYTE_LO;
            end else begin
              state <= BYTE_HI;
            end
          end
          BYTE_LO: begin
            if (href_fall) begin
              LINE_DONE <= 1'b1;
              if (x_cnt < SCR_W) begin
                LINE_ERR <= 1'b1;
              end else begin
                LINE_ERR <= LINE_ERR;
              end
              x_cnt <= '0;
              y_cnt <= y_next;
              state <= WAIT_LINE;
            end else if (href_q) begin
              lo_byte <= d_q;
              state   <= BYTE_HI;
            end else begin
              state <= BYTE_LO;
            end
          end
          default: state <= WAIT_VS;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_camera_pixel_capture.sv
// Randomised scoreboard bench for camera_pixel_capture: a byte-level frame model predicts writes,
// line ends and frame ends; a monitor pops and compares whenever the DUT strobes an output.
module tb_camera_pixel_capture;
  localparam int SW = 176;
  localparam int SH = 144;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [7:0]  CAMERA_DATA = 8'd0;
  logic        HREF = 1'b0;
  logic        VSYNC = 1'b1;
  logic [15:0] PIXEL_RGB565;
  logic [7:0]  X_ADDR;
  logic [7:0]  Y_ADDR;
  logic        W_EN;
  logic        LINE_DONE;
  logic        FRAME_DONE;
  logic [7:0]  LINE_COUNT;
  logic        LINE_ERR;

  camera_pixel_capture dut (
    .CLK(CLK), .RESET_N(RESET_N), .CAMERA_DATA(CAMERA_DATA), .HREF(HREF), .VSYNC(VSYNC),
    .PIXEL_RGB565(PIXEL_RGB565), .X_ADDR(X_ADDR), .Y_ADDR(Y_ADDR), .W_EN(W_EN),
    .LINE_DONE(LINE_DONE), .FRAME_DONE(FRAME_DONE), .LINE_COUNT(LINE_COUNT), .LINE_ERR(LINE_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] p;
  } wr_t;

  wr_t        q_wr[$];
  logic       q_line[$];
  logic [7:0] q_frame[$];
  int total = 0;
  int bad   = 0;
  int n_wr  = 0;

  // reference model state: capturing, mid-line, odd byte pending, sticky error, pixel/line counts
  bit         m_cap = 1'b0;
  bit         m_inline = 1'b0;
  bit         m_half = 1'b0;
  bit         m_err = 1'b0;
  int         m_x = 0;
  int         m_y = 0;
  logic [7:0] m_lo = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int x, input logic [15:0] raw);
`ifdef CAPTURE_TEST_PATTERN_EN
    int idx;
    logic [2:0] b;
    idx = x / (SW / 8);
    b = idx[2:0];
    return {{5{b[2]}}, {6{b[1]}}, {5{b[0]}}};
`else
    return raw;
`endif
  endfunction

  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    if (m_cap) begin
      m_inline = 1'b1;
      if (!m_half) begin
        m_lo = b;
        m_half = 1'b1;
      end else begin
        if (m_x < SW && m_y < SH) begin
          w.x = 8'(m_x);
          w.y = 8'(m_y);
          w.p = exp_pix(m_x, {b, m_lo});
          q_wr.push_back(w);
        end
        if (m_x < SW) m_x++;
        m_half = 1'b0;
      end
    end
  endtask

  task automatic model_line_end();
    m_inline = 1'b0;
    if (m_cap) begin
      m_err = m_err | m_half | (m_x < SW);
      q_line.push_back(m_err);
      m_y = (m_y == 255) ? 255 : m_y + 1;
      m_x = 0;
      m_half = 1'b0;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge CLK);
    HREF = 1'b1;
    CAMERA_DATA = b;
    model_byte(b);
  endtask

  task automatic send_line(input int n, input bit rnd);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (rnd) b = 8'($urandom);
      else     b = (i % 2 != 0) ? 8'hF8 : 8'h00;
      drive_byte(b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      HREF = 1'b0;
      CAMERA_DATA = 8'($urandom);
      if (m_inline) model_line_end();
    end
  endtask

  // VSYNC rise; if HREF was still high, this is the coincident line-abort case
  task automatic vs_up();
    @(negedge CLK);
    HREF = 1'b0;
    VSYNC = 1'b1;
    m_inline = 1'b0;
    if (m_cap) q_frame.push_back(8'(m_y));
    m_cap = 1'b0;
    m_x = 0;
    m_half = 1'b0;
  endtask

  task automatic vs_down();
    @(negedge CLK);
    VSYNC = 1'b0;
    m_cap = 1'b1;
    m_y = 0;
    m_err = 1'b0;
    m_x = 0;
    m_half = 1'b0;
    m_inline = 1'b0;
  endtask

  // monitor: pops expectations whenever the DUT strobes an output
  initial begin
    wr_t e;
    logic le;
    logic [7:0] fe;
    forever begin
      @(posedge CLK);
      #1;
      if (W_EN) begin
        n_wr++;
        if (q_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wr: got W_EN=1 at x=%0d y=%0d want no write", X_ADDR, Y_ADDR);
        end else begin
          e = q_wr.pop_front();
          chk("wr_x", 32'(X_ADDR), 32'(e.x));
          chk("wr_y", 32'(Y_ADDR), 32'(e.y));
          chk("wr_pixel", 32'(PIXEL_RGB565), 32'(e.p));
        end
      end
      if (LINE_DONE) begin
        if (q_line.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_line_done: got LINE_DONE=1 want 0");
        end else begin
          le = q_line.pop_front();
          chk("line_err_at_line_done", 32'(LINE_ERR), 32'(le));
        end
      end
      if (FRAME_DONE) begin
        if (q_frame.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame_done: got FRAME_DONE=1 want 0");
        end else begin
          fe = q_frame.pop_front();
          chk("line_count", 32'(LINE_COUNT), 32'(fe));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    repeat (3) @(negedge CLK);
    chk("reset_wen", 32'(W_EN), 32'd0);
    chk("reset_pixel", 32'(PIXEL_RGB565), 32'd0);
    chk("reset_status", 32'({LINE_DONE, FRAME_DONE, LINE_ERR, LINE_COUNT, X_ADDR, Y_ADDR}), 32'd0);
    RESET_N = 1'b1;
    idle(4);

    // single 0x00,0xF8 line: 176 writes of F800 on row 0
    vs_down(); idle(4);
    n0 = n_wr;
    send_line(352, 1'b0); idle(3);
    chk("line1_writes", 32'(n_wr - n0), 32'd176);
    chk("line1_err", 32'(LINE_ERR), 32'd0);
    vs_up(); idle(4);

    // full random frame
    vs_down(); idle(4);
    n0 = n_wr;
    for (int l = 0; l < SH; l++) begin
      send_line(352, 1'b1); idle(3);
    end
    vs_up(); idle(4);
    chk("frame_writes", 32'(n_wr - n0), 32'd25344);
    chk("frame_err", 32'(LINE_ERR), 32'd0);

    // long line plus 150-line frame: clipping in X and Y
    vs_down(); idle(4);
    n0 = n_wr;
    send_line(400, 1'b1); idle(3);
    for (int l = 1; l < 150; l++) begin
      send_line(4, 1'b1); idle(3);
    end
    vs_up(); idle(4);
    chk("clip_writes", 32'(n_wr - n0), 32'd462);

    // odd-length line: 175 writes, sticky error until next VSYNC fall
    vs_down(); idle(4);
    n0 = n_wr;
    send_line(351, 1'b1); idle(3);
    chk("odd_writes", 32'(n_wr - n0), 32'd175);
    chk("odd_err_set", 32'(LINE_ERR), 32'(m_err));
    send_line(352, 1'b1); idle(3);
    vs_up(); idle(4);
    chk("odd_err_held", 32'(LINE_ERR), 32'd1);
    vs_down(); idle(4);
    chk("odd_err_cleared", 32'(LINE_ERR), 32'd0);

    // coincident HREF fall and VSYNC rise: second line uncounted
    idle(2);
    send_line(352, 1'b1); idle(3);
    send_line(40, 1'b1);
    vs_up(); idle(4);

    // LINE_COUNT saturation
    vs_down(); idle(4);
    for (int l = 0; l < 260; l++) begin
      send_line(2, 1'b1); idle(3);
    end
    vs_up(); idle(4);

    // reset mid-line, release mid-frame, resume after a full VSYNC pulse
    vs_down(); idle(4);
    send_line(352, 1'b1); idle(3);
    send_line(100, 1'b1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rst_addr", 32'({X_ADDR, Y_ADDR}), 32'd0);
    chk("async_rst_out", 32'({PIXEL_RGB565, W_EN, LINE_DONE, FRAME_DONE, LINE_ERR, LINE_COUNT}), 32'd0);
    q_wr.delete(); q_line.delete(); q_frame.delete();
    m_cap = 1'b0; m_inline = 1'b0; m_half = 1'b0; m_x = 0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    n0 = n_wr;
    send_line(100, 1'b1); idle(3);
    send_line(352, 1'b1); idle(3);
    chk("post_rst_no_wr", 32'(n_wr - n0), 32'd0);
    vs_up(); idle(4);
    vs_down(); idle(4);
    send_line(352, 1'b0); idle(3);
    vs_up(); idle(10);

    chk("wr_queue_empty", 32'(q_wr.size()), 32'd0);
    chk("line_queue_empty", 32'(q_line.size()), 32'd0);
    chk("frame_queue_empty", 32'(q_frame.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
